// File: rtl/mc_control.sv
// Multicycle MIPS main controller: Moore FSM sequencing the shared ALU, unified memory
// and register file; only the memory-handshake strobes and the illegal-opcode pulse are combinational.
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       instrdone;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;
    state_t state_nx;
    ctl_t   ctl_q;
    ctl_t   ctl;
    logic   live;

    // Moore output table; registered against the next state so outputs are glitch-free.
    function automatic ctl_t moore(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.memread = 1'b1; c.alusrcb = 2'b01; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   begin c.iord = 1'b1; c.memread = 1'b1; end
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.instrdone = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.instrdone = 1'b1; end
            BEQEX:   begin
                c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                c.branch = 1'b1; c.instrdone = 1'b1;
            end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  begin c.regwrite = 1'b1; c.instrdone = 1'b1; end
            JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.instrdone = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:   state_nx = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_RTYPE:     state_nx = RTYPEEX;
                    OP_BEQ:       state_nx = BEQEX;
                    OP_ADDI:      state_nx = ADDIEX;
                    OP_J:         state_nx = JEX;
                    default:      state_nx = FETCH;
                endcase
            end
            MEMADR:  state_nx = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_nx = MemReady ? MEMWB : MEMRD;
            MEMWR:   state_nx = MemReady ? FETCH : MEMWR;
            RTYPEEX: state_nx = RTYPEWB;
            ADDIEX:  state_nx = ADDIWB;
            default: state_nx = FETCH;
        endcase
    end

    // The reset value of ctl_q is the FETCH row so the cycle after release already drives FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctl_q <= moore(FETCH);
        end else begin
            state <= state_nx;
            ctl_q <= moore(state_nx);
        end
    end

    // Reset masks every output immediately, without waiting for a clock edge.
    assign live = ~reset;

    always_comb begin
        ctl = '0;
        if (live) ctl = ctl_q;
    end

    assign IorD      = ctl.iord;
    assign MemRead   = ctl.memread;
    assign MemWrite  = ctl.memwrite;
    assign Branch    = ctl.branch;
    assign PCSrc     = ctl.pcsrc;
    assign ALUSrcA   = ctl.alusrca;
    assign ALUSrcB   = ctl.alusrcb;
    assign ALUOp     = ctl.aluop;
    assign RegDst    = ctl.regdst;
    assign MemToReg  = ctl.memtoreg;
    assign RegWrite  = ctl.regwrite;
    assign IRWrite   = live & (state == FETCH) & MemReady;
    assign PCWrite   = ctl.pcwrite | IRWrite;
    assign IllegalOp = live & (state == DECODE) & ~legal_op(Op);
    assign InstrDone = ctl.instrdone | (live & (state == MEMWR) & MemReady) | IllegalOp;
    assign State     = live ? state : 4'd0;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: expected outputs per cycle come from a spec-table model
// keyed on the intended state sequence, queued at drive time and compared at sample time.
module tb_mc_control;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       instrdone;
        logic       illegalop;
        logic [3:0] state;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic       ALUSrcA, RegDst, MemToReg, RegWrite, InstrDone, IllegalOp;
    logic [3:0] State;

    int   tests = 0;
    int   fails = 0;
    obs_t sbq[$];

    mc_control dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .InstrDone(InstrDone), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.iord = IorD; o.memread = MemRead; o.memwrite = MemWrite; o.irwrite = IRWrite;
        o.pcwrite = PCWrite; o.branch = Branch; o.pcsrc = PCSrc; o.alusrca = ALUSrcA;
        o.alusrcb = ALUSrcB; o.aluop = ALUOp; o.regdst = RegDst; o.memtoreg = MemToReg;
        o.regwrite = RegWrite; o.instrdone = InstrDone; o.illegalop = IllegalOp;
        o.state = State;
        return o;
    endfunction

    // Expected outputs for one cycle spent in state st, straight from the state table.
    function automatic obs_t model(input logic [3:0] st, input logic mr, input logic [5:0] op);
        obs_t o;
        logic legal;
        o = '0;
        o.state = st;
        legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
                (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
        case (st)
            4'd0: begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
            4'd1: begin o.alusrcb = 2'b11; o.illegalop = !legal; o.instrdone = !legal; end
            4'd2: begin o.alusrca = 1; o.alusrcb = 2'b10; end
            4'd3: begin o.iord = 1; o.memread = 1; end
            4'd4: begin o.memtoreg = 1; o.regwrite = 1; o.instrdone = 1; end
            4'd5: begin o.iord = 1; o.memwrite = 1; o.instrdone = mr; end
            4'd6: begin o.alusrca = 1; o.aluop = 2'b10; end
            4'd7: begin o.regdst = 1; o.regwrite = 1; o.instrdone = 1; end
            4'd8: begin
                o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch = 1; o.instrdone = 1;
            end
            4'd9: begin o.alusrca = 1; o.alusrcb = 2'b10; end
            4'd10: begin o.regwrite = 1; o.instrdone = 1; end
            4'd11: begin o.pcsrc = 2'b10; o.pcwrite = 1; o.instrdone = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        obs_t e;
        sbq.push_back(exp);
        got = sample();
        e = sbq.pop_front();
        tests++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    // Called just after a falling edge: drive, settle, compare, advance one cycle.
    task automatic step(input string tag, input logic [5:0] op, input logic mr, input logic [3:0] st);
        Op = op;
        MemReady = mr;
        #1;
        check(tag, model(st, mr, op));
        @(negedge clk);
    endtask

    task automatic reset_mid(input string tag);
        MemReady = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_async"}, '0);
        @(posedge clk);
        #1;
        check({tag, "_held"}, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        Op = 6'b000000;
        MemReady = 1'b0;
        #2;
        check("reset_idle", '0);
        MemReady = 1'b1;
        #1;
        check("reset_memready", '0);
        @(negedge clk);
        reset = 1'b0;

        step("rt_fetch",  6'b000000, 1'b1, 4'd0);
        step("rt_decode", 6'b000000, 1'b1, 4'd1);
        step("rt_ex",     6'b000000, 1'b1, 4'd6);
        step("rt_wb",     6'b000000, 1'b1, 4'd7);

        step("lw_fetch",  6'b100011, 1'b1, 4'd0);
        step("lw_decode", 6'b100011, 1'b1, 4'd1);
        step("lw_adr",    6'b100011, 1'b1, 4'd2);
        step("lw_rd0",    6'b100011, 1'b0, 4'd3);
        step("lw_rd1",    6'b100011, 1'b0, 4'd3);
        step("lw_rd2",    6'b100011, 1'b1, 4'd3);
        step("lw_wb",     6'b100011, 1'b1, 4'd4);

        step("sw_fetch",  6'b101011, 1'b1, 4'd0);
        step("sw_decode", 6'b101011, 1'b1, 4'd1);
        step("sw_adr",    6'b101011, 1'b1, 4'd2);
        step("sw_wr",     6'b101011, 1'b1, 4'd5);

        step("beq_fetch",  6'b000100, 1'b1, 4'd0);
        step("beq_decode", 6'b000100, 0, 4'd1);
        step("beq_ex",     6'b000100, 1'b1, 4'd8);

        step("fw_wait0",  6'b000010, 1'b0, 4'd0);
        step("fw_wait1",  6'b000010, 1'b0, 4'd0);
        step("fw_wait2",  6'b000010, 1'b0, 4'd0);
        step("fw_ready",  6'b000010, 1'b1, 4'd0);
        step("j_decode",  6'b000010, 1'b1, 4'd1);
        step("j_ex",      6'b000010, 1'b0, 4'd11);

        step("ill_fetch",  6'b111111, 1'b1, 4'd0);
        step("ill_decode", 6'b111111, 1'b1, 4'd1);
        step("ill_after",  6'b111111, 1'b0, 4'd0);
        step("ill_fetch2", 6'b001000, 1'b1, 4'd0);

        step("addi_decode", 6'b001000, 1'b1, 4'd1);
        step("addi_ex",     6'b001000, 1'b1, 4'd9);
        step("addi_wb",     6'b001000, 1'b1, 4'd10);

        step("swr_fetch",  6'b101011, 1'b1, 4'd0);
        step("swr_decode", 6'b101011, 1'b1, 4'd1);
        step("swr_adr",    6'b101011, 1'b1, 4'd2);
        step("swr_wait",   6'b101011, 1'b0, 4'd5);
        reset_mid("rst_memwr");
        step("swr_refetch", 6'b000000, 1'b1, 4'd0);

        step("rtr_decode", 6'b000000, 1'b1, 4'd1);
        step("rtr_ex",     6'b000000, 1'b1, 4'd6);
        #2;
        reset = 1'b1;
        #1;
        check("rst_rtypewb_async", '0);
        @(posedge clk);
        #1;
        check("rst_rtypewb_held", '0);
        @(negedge clk);
        reset = 1'b0;
        step("rtr_refetch", 6'b000000, 1'b0, 4'd0);
        step("rtr_fetch1",  6'b000000, 1'b1, 4'd0);
        step("rtr_decode2", 6'b000000, 1'b1, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main controller for the MIPS datapath. It sequences one shared ALU, one unified instruction/data memory and the register file across several cycles per instruction. Its inputs are the 6-bit opcode latched in the instruction register and a memory-ready handshake. It drives every datapath select and write strobe from a Moore state machine; the only exceptions are strobes gated by the memory handshake. It supersedes the single-cycle opcode decoder for the multicycle build and supports R-type, lw, sw, beq, addi and j.

## Interface
- No parameters. Opcode encodings are fixed: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- Op  in  6  opcode from instruction register (bits 31:26)
- MemReady  in  1  memory completes the current read/write this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1  memory strobes, held until MemReady
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load; datapath qualifies it with Zero
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- ALUOp  out  2  00 = add, 01 = subtract, 10 = funct field decides
- RegDst  out  1  0 = rt, 1 = rd
- MemToReg  out  1  0 = ALUOut, 1 = memory data register
- RegWrite  out  1  register file write
- InstrDone  out  1  one-cycle pulse on the final cycle of each instruction
- IllegalOp  out  1  one-cycle pulse in DECODE for an unsupported opcode
- State  out  4  current state encoding, for debug and verification

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite = PCWrite = MemReady.
  - Next state: stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Op: lw/sw → MEMADR, R-type → RTYPEEX, beq → BEQEX, addi → ADDIEX, j → JEX.
  - Any other opcode: IllegalOp=1, InstrDone=1, next state FETCH.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: IorD=1, MemRead=1; stay until MemReady=1, then go to MEMWB.
- MEMWB: MemToReg=1, RegWrite=1, InstrDone=1; next state FETCH.
- MEMWR: IorD=1, MemWrite=1; stay until MemReady=1. In the MemReady cycle assert InstrDone=1, then go to FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RTYPEWB.
- RTYPEWB: RegDst=1, RegWrite=1, InstrDone=1; next state FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, InstrDone=1; next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1, InstrDone=1; next state FETCH.
- JEX: PCSrc=10, PCWrite=1, InstrDone=1; next state FETCH.
- Op is sampled only in DECODE and MEMADR. The instruction register is stable in both because IRWrite=0 outside FETCH.

## Timing
- Reset:
  - While reset is high, all outputs are 0, State=0, and every write strobe is suppressed.
  - The first rising edge after deassertion is spent in FETCH, with outputs as defined for FETCH.
- Mid-instruction reset: the state is abandoned immediately and asynchronously. No RegWrite, MemWrite or PCWrite is asserted afterwards for that instruction.
- Latency with zero-wait memory (MemReady tied high):
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j, illegal opcode: 2–3 cycles (beq and j take 3; an illegal opcode takes 2)
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRead and MemWrite stay high continuously until the MemReady cycle. They are never both high in the same cycle.
- InstrDone is high for exactly one cycle per instruction and always precedes a FETCH.
- MemReady asserted outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- R-type (Op=000000), MemReady=1: State sequence 0,1,6,7,0. ALUOp=10 in state 6. RegDst=1 and RegWrite=1 only in state 7. InstrDone pulses once, in cycle 4.
- lw (Op=100011) with MemReady low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. MemRead held high through all three MEMRD cycles. MemToReg=1 and RegWrite=1 in state 4. Total 7 cycles.
- sw (Op=101011), then beq (Op=000100):
  - sw: MemWrite=1 only in state 5; RegWrite never asserted.
  - beq: Branch=1, PCSrc=01, ALUOp=01 in state 8; PCWrite=0 there.
- FETCH with MemReady=0 for 3 cycles: IRWrite and PCWrite stay 0 until the MemReady cycle, then both pulse for one cycle. State stays 0 throughout the wait.
- Op=111111 in DECODE: IllegalOp=1 and InstrDone=1 for one cycle, next State=0. No write strobe is asserted during the instruction.
- Reset asserted in MEMWR and in RTYPEWB: all outputs go to 0 in the same cycle, with no clock edge needed. MemWrite and RegWrite are never seen asserted after the reset edge. After release, State=0 and FETCH begins.
